// File: rtl/golden_nonce_fifo.sv
// golden_nonce_fifo
//   Captures golden nonces reported by the double-hash miner pipe.
//   A new non-zero golden_nonce value is a hit. The nonce is corrected by
//   NONCE_ADJ and queued in a first-word-fall-through FIFO, which the host
//   drains with a valid/ready handshake. The block also keeps a found
//   counter, a saturating overflow counter and an on-demand progress
//   snapshot of nonce2/hash2.
//
// Ports
//   clk           clock, all state updates on posedge
//   reset         synchronous reset, active low
//   golden_nonce  miner golden nonce (0 = nothing found yet)
//   nonce2/hash2  miner progress words, captured on snap_req
//   clear         synchronous flush of the FIFO and both counters
//   out_valid     FIFO is not empty
//   out_nonce     head entry (FWFT), 0 when the FIFO is empty
//   out_ready     host accepts the head entry while out_valid is high
//   count         number of entries held, 0..DEPTH
//   found_cnt     hits since reset or clear, wraps
//   overflow_cnt  hits dropped because the FIFO was full, saturates at 255
//   snap_req      capture nonce2/hash2 into snap_nonce/snap_hash
module golden_nonce_fifo #(
  parameter int          DEPTH     = 8,
  parameter int          ADDR_W    = 3,
  parameter logic [31:0] NONCE_ADJ = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       golden_nonce,
  input  logic [31:0]       nonce2,
  input  logic [31:0]       hash2,
  input  logic              clear,
  output logic              out_valid,
  output logic [31:0]       out_nonce,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic [31:0]       found_cnt,
  output logic [7:0]        overflow_cnt,
  input  logic              snap_req,
  output logic [31:0]       snap_nonce,
  output logic [31:0]       snap_hash
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       prev_golden;

  logic        hit;
  logic        pop;
  logic        push;
  logic        drop;
  logic [31:0] entry;

  // A held value only produces one hit; zero means "no nonce yet".
  assign hit   = (golden_nonce != prev_golden) && (golden_nonce != 32'd0);
  assign entry = golden_nonce - NONCE_ADJ;

  // out_ready is ignored while empty, so a pop implies count != 0.
  assign pop  = out_valid && out_ready;
  // A full FIFO still accepts a hit when the head leaves on the same edge.
  assign push = hit && !clear && ((count != FULL_CNT) || pop);
  assign drop = hit && !clear && !push;

  // Outputs come from registered state only; out_ready never reaches them.
  assign out_valid = (count != '0);
  assign out_nonce = out_valid ? mem[rd_ptr] : 32'd0;

  // Storage carries no reset: count decides which slots are meaningful.
  // When full with a simultaneous pop, wr_ptr == rd_ptr and the slot being
  // overwritten is the head that leaves on this very edge.
  always_ff @(posedge clk) begin
    if (reset && push)
      mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      prev_golden  <= 32'd0;
      found_cnt    <= 32'd0;
      overflow_cnt <= 8'd0;
    end else begin
      // Tracks the input on clear edges too, so a hit swallowed by clear
      // is not re-detected on the following edge.
      prev_golden <= golden_nonce;

      if (clear) begin
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        count        <= '0;
        found_cnt    <= 32'd0;
        overflow_cnt <= 8'd0;
      end else begin
        if (pop)
          rd_ptr <= rd_ptr + PTR_ONE;
        if (push)
          wr_ptr <= wr_ptr + PTR_ONE;

        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase

        if (hit)
          found_cnt <= found_cnt + 32'd1;
        if (drop && (overflow_cnt != 8'hFF))
          overflow_cnt <= overflow_cnt + 8'd1;
      end
    end
  end

  // Progress snapshot is independent of clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      snap_nonce <= 32'd0;
      snap_hash  <= 32'd0;
    end else if (snap_req) begin
      snap_nonce <= nonce2;
      snap_hash  <= hash2;
    end
  end

endmodule
